// File: rtl/display_ndigit_dimmable.sv
// Multiplexed N-digit seven-segment driver with PWM dimming,
// leading-zero blanking and frame-synchronous input latching.
module display_ndigit_dimmable #(
    parameter int NDIGITS     = 8,
    parameter int DIV_BITS    = 12,
    parameter int BRIGHT_BITS = 4,
    parameter int GUARD       = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4*NDIGITS-1:0]   val,
    input  logic [NDIGITS-1:0]     dp,
    input  logic [NDIGITS-1:0]     digit_en,
    input  logic                   lz_blank,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic [7:0]             segments,
    output logic [NDIGITS-1:0]     digitselect,
    output logic                   frame_start
);

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic [DIV_BITS-1:0]    tick;
    logic [IW-1:0]          idx;
    logic                   first;
    logic [4*NDIGITS-1:0]   sval;
    logic [NDIGITS-1:0]     sdp;
    logic [NDIGITS-1:0]     sen;
    logic                   slz;
    logic [BRIGHT_BITS-1:0] sbr;

    logic tick_wrap;
    logic idx_last;
    logic capture;

    assign tick_wrap = &tick;
    assign idx_last  = (idx == IW'(NDIGITS - 1));
    assign capture   = first | (tick_wrap & idx_last);

    // Dwell counter and digit index; idx steps once per dwell.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick <= '0;
            idx  <= '0;
        end else begin
            tick <= tick + 1'b1;
            if (tick_wrap)
                idx <= idx_last ? '0 : idx + 1'b1;
        end
    end

    // Shadow copy of the inputs, refreshed only at frame boundaries.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            first       <= 1'b1;
            sval        <= '0;
            sdp         <= '0;
            sen         <= '0;
            slz         <= 1'b0;
            sbr         <= '0;
            frame_start <= 1'b0;
        end else begin
            first       <= 1'b0;
            frame_start <= capture;
            if (capture) begin
                sval <= val;
                sdp  <= dp;
                sen  <= digit_en;
                slz  <= lz_blank;
                sbr  <= brightness;
            end
        end
    end

    logic [NDIGITS-1:0]     zup;
    logic                   acc;
    logic [3:0]             nib;
    logic                   dpb;
    logic                   enb;
    logic                   zb;
    logic [BRIGHT_BITS-1:0] phase;
    logic                   lit;
    logic [6:0]             dec;

    // Select the current digit and decide whether it is lit this clock.
    always_comb begin
        acc = 1'b1;
        zup = '0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            acc    = acc & (sval[4*i +: 4] == 4'h0);
            zup[i] = acc;
        end
        nib = 4'h0;
        dpb = 1'b0;
        enb = 1'b0;
        zb  = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib = sval[4*i +: 4];
                dpb = sdp[i];
                enb = sen[i];
                zb  = zup[i];
            end
        end
        phase = tick[DIV_BITS-1 -: BRIGHT_BITS];
        lit = enb
            & ~(slz & (idx != '0) & zb)
            & (tick >= DIV_BITS'(GUARD))
            & ((&sbr) | (phase < sbr));
    end

    // Hex to active-low a..g pattern.
    always_comb begin
        dec = 7'h7F;
        unique case (nib)
            4'h0: dec = 7'h40;
            4'h1: dec = 7'h79;
            4'h2: dec = 7'h24;
            4'h3: dec = 7'h30;
            4'h4: dec = 7'h19;
            4'h5: dec = 7'h12;
            4'h6: dec = 7'h02;
            4'h7: dec = 7'h78;
            4'h8: dec = 7'h00;
            4'h9: dec = 7'h10;
            4'hA: dec = 7'h08;
            4'hB: dec = 7'h03;
            4'hC: dec = 7'h46;
            4'hD: dec = 7'h21;
            4'hE: dec = 7'h06;
            4'hF: dec = 7'h0E;
        endcase
    end

    // Registered pin drivers; dark whenever the digit is not lit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            segments    <= 8'hFF;
            digitselect <= '1;
        end else if (lit) begin
            segments    <= {~dpb, dec};
            digitselect <= ~(NDIGITS'(1) << idx);
        end else begin
            segments    <= 8'hFF;
            digitselect <= '1;
        end
    end

endmodule

// File: tb/tb_display_ndigit_dimmable.sv
// Scoreboard bench for display_ndigit_dimmable (4 digits,
// 16-clock dwell, 2-bit brightness, 1-clock guard).
module tb_display_ndigit_dimmable;

    logic        clock;
    logic        reset;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [1:0]  brightness;
    logic [7:0]  segments;
    logic [3:0]  digitselect;
    logic        frame_start;

    display_ndigit_dimmable #(
        .NDIGITS(4), .DIV_BITS(4), .BRIGHT_BITS(2), .GUARD(1)
    ) dut (
        .clock(clock), .reset(reset), .val(val), .dp(dp),
        .digit_en(digit_en), .lz_blank(lz_blank),
        .brightness(brightness), .segments(segments),
        .digitselect(digitselect), .frame_start(frame_start)
    );

    typedef struct {
        int         cyc;
        logic [3:0] ds;
        logic [7:0] seg;
        logic       fs;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   checks = 0;
    int   passed = 0;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: compare every queued expectation at its cycle.
    always @(negedge clock) begin
        if (!reset) begin
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (e.cyc != cyc)
                    $display("FAIL %s cyc %0d missed (now %0d)",
                             e.name, e.cyc, cyc);
                else if (digitselect !== e.ds || segments !== e.seg
                         || frame_start !== e.fs)
                    $display("FAIL %s cyc %0d got ds=%h seg=%h fs=%b want ds=%h seg=%h fs=%b",
                             e.name, cyc, digitselect, segments,
                             frame_start, e.ds, e.seg, e.fs);
                else
                    passed++;
            end
        end
    end

    // Push expectations for output cycles k0..k1; tab holds the
    // lit pattern of digits 3..0, msk the digits that may light.
    task automatic push(input string nm, input int k0, input int k1,
                        input logic [31:0] tab, input logic [3:0] msk,
                        input int tlo, input int thi);
        for (int k = k0; k <= k1; k++) begin
            exp_t e;
            int t, d;
            bit on;
            t = (k - 1) % 16;
            d = ((k - 1) / 16) % 4;
            on = (k >= 2) && msk[d] && t >= tlo && t <= thi;
            e.cyc  = k;
            e.name = nm;
            e.fs   = (k == 1) || (k % 64 == 0);
            e.ds   = on ? ~(4'b0001 << d) : 4'hF;
            e.seg  = on ? tab[8*d +: 8] : 8'hFF;
            q.push_back(e);
        end
    endtask

    task automatic start(input logic [15:0] v, input logic [3:0] p,
                         input logic [3:0] en, input logic lz,
                         input logic [1:0] br);
        reset = 1;
        q.delete();
        val = v; dp = p; digit_en = en;
        lz_blank = lz; brightness = br;
        @(negedge clock);
    endtask

    task automatic go();
        #2 reset = 0;
    endtask

    task automatic finish_run(input string nm, input int n);
        repeat (n + 2) @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0)
            $display("FAIL %s timeout: %0d left, want 0", nm, q.size());
        else
            passed++;
    endtask

    task automatic direct(input string nm, input logic [3:0] ds,
                          input logic [7:0] seg);
        checks++;
        if (digitselect !== ds || segments !== seg)
            $display("FAIL %s got ds=%h seg=%h want ds=%h seg=%h",
                     nm, digitselect, segments, ds, seg);
        else
            passed++;
    endtask

    initial begin
        reset = 1;
        val = '0; dp = '0; digit_en = '0;
        lz_blank = 0; brightness = '0;
        #3;
        direct("reset_state", 4'hF, 8'hFF);
        checks++;
        if (frame_start !== 1'b0)
            $display("FAIL reset_fs got %b want 0", frame_start);
        else
            passed++;

        start(16'h12AF, 4'h0, 4'hF, 0, 2'd3);
        push("full", 1, 140, 32'hF9_A4_88_8E, 4'hF, 1, 15);
        go();
        finish_run("full", 140);

        start(16'h0030, 4'h0, 4'hF, 1, 2'd3);
        push("lzb_on", 1, 140, 32'hFF_FF_B0_C0, 4'b0011, 1, 15);
        go();
        finish_run("lzb_on", 140);

        start(16'h0030, 4'h0, 4'hF, 0, 2'd3);
        push("lzb_off", 1, 140, 32'hC0_C0_B0_C0, 4'hF, 1, 15);
        go();
        finish_run("lzb_off", 140);

        start(16'h12AF, 4'h0, 4'hF, 0, 2'd1);
        push("bright1", 1, 140, 32'hF9_A4_88_8E, 4'hF, 1, 3);
        go();
        finish_run("bright1", 140);

        start(16'h12AF, 4'h0, 4'hF, 0, 2'd0);
        push("bright0", 1, 140, 32'hF9_A4_88_8E, 4'h0, 1, 15);
        go();
        finish_run("bright0", 140);

        start(16'h1111, 4'h0, 4'hF, 0, 2'd3);
        push("tear_a", 1, 65, 32'hF9_F9_F9_F9, 4'hF, 1, 15);
        push("tear_b", 66, 200, 32'hA4_A4_A4_A4, 4'hF, 1, 15);
        go();
        wait (cyc == 40);
        @(negedge clock);
        val = 16'h2222;
        finish_run("tear", 160);

        start(16'h1111, 4'b0001, 4'b1011, 0, 2'd3);
        push("dp_en", 1, 140, 32'hF9_FF_F9_79, 4'b1011, 1, 15);
        go();
        finish_run("dp_en", 140);

        start(16'h12AF, 4'h0, 4'hF, 0, 2'd3);
        push("pre_rst", 1, 21, 32'hF9_A4_88_8E, 4'hF, 1, 15);
        go();
        wait (cyc == 21);
        @(negedge clock);
        #1;
        direct("pre_rst_lit", 4'hD, 8'h88);
        @(posedge clock);
        #3 reset = 1;
        q.delete();
        #1;
        direct("async_rst", 4'hF, 8'hFF);
        start(16'h12AF, 4'h0, 4'hF, 0, 2'd3);
        push("post_rst", 1, 70, 32'hF9_A4_88_8E, 4'hF, 1, 15);
        go();
        finish_run("post_rst", 70);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
